// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control path: state encodings and the
// default digit limits of the 0-59 seconds counter.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam int TS_MAX_DEF = 5;
  localparam int SS_MAX_DEF = 9;

  // The counter advances, and the button is reported as running, in both RUN and LAP.
  function automatic logic is_active(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector for an already-synchronous push-button level.
// The previous-level register resets high, so a button held through reset is ignored.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= btn;
    end
  end

  assign press = btn & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop and lap/clear control for the seconds counter: gates the 1 Hz tick,
// issues the counter clear and freezes the display on a captured lap value.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TS_MAX = TS_MAX_DEF,
  parameter int SS_MAX = SS_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic [2:0] ts,
  input  logic [3:0] ss,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [2:0] ts_out,
  output logic [3:0] ss_out,
  output logic       min_tick,
  output logic       running
);

  state_t     state;
  state_t     next_state;
  logic       ss_press;
  logic       lap_press;
  logic       lap_load;
  logic       clr_go;
  logic [2:0] lap_ts;
  logic [3:0] lap_ss;

  btn_edge u_edge_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_ss),
    .press (ss_press)
  );

  btn_edge u_edge_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .press (lap_press)
  );

  // A start/stop press always takes priority; a lap press in the same cycle is dropped.
  always_comb begin
    next_state = state;
    lap_load   = 1'b0;
    clr_go     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_press) next_state = RUN;
      end
      RUN: begin
        if (ss_press) begin
          next_state = STOP;
        end else if (lap_press) begin
          next_state = LAP;
          lap_load   = 1'b1;
        end
      end
      LAP: begin
        if (ss_press) begin
          next_state = STOP;
        end else if (lap_press) begin
          next_state = RUN;
        end
      end
      STOP: begin
        if (ss_press) begin
          next_state = RUN;
        end else if (lap_press) begin
          next_state = IDLE;
          clr_go     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt_clr <= 1'b0;
      lap_ts  <= '0;
      lap_ss  <= '0;
    end else begin
      state   <= next_state;
      cnt_clr <= clr_go;
      if (lap_load) begin
        lap_ts <= ts;
        lap_ss <= ss;
      end else if (clr_go) begin
        lap_ts <= '0;
        lap_ss <= '0;
      end
    end
  end

  // Lap capture samples the live digits at the press edge, i.e. before any coincident increment.
  assign running  = is_active(state);
  assign cnt_en   = tick & running;
  assign min_tick = cnt_en & (ts == 3'(TS_MAX)) & (ss == 4'(SS_MAX));
  assign ts_out   = (state == LAP) ? lap_ts : ts;
  assign ss_out   = (state == LAP) ? lap_ss : ss;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a bench-side 0-59 counter closes the loop,
// a behavioural model is compared every cycle, and directed literals pin key points.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       btn_ss;
  logic       btn_lap;
  logic [2:0] ts;
  logic [3:0] ss;
  logic       cnt_en;
  logic       cnt_clr;
  logic [2:0] ts_out;
  logic [3:0] ss_out;
  logic       min_tick;
  logic       running;

  int checks = 0;
  int errors = 0;

  int secs = 0;
  int enCount = 0;

  stopwatch_ctrl #(.TS_MAX(5), .SS_MAX(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .btn_ss   (btn_ss),
    .btn_lap  (btn_lap),
    .ts       (ts),
    .ss       (ss),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .ts_out   (ts_out),
    .ss_out   (ss_out),
    .min_tick (min_tick),
    .running  (running)
  );

  always #5 clk = ~clk;

  // Seconds counter that the controller drives; it shares the same reset.
  assign ts = 3'(secs / 10);
  assign ss = 4'(secs % 10);

  always @(posedge clk) begin
    if (reset) begin
      secs <= 0;
    end else if (cnt_clr) begin
      secs <= 0;
    end else if (cnt_en) begin
      secs <= (secs + 1) % 60;
      enCount <= enCount + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: what the stopwatch is doing, described as flags and a lap time in seconds.
  bit modelValid = 0;
  bit mCounting, mStopped, mFrozen, mClr, mPrevSs, mPrevLap;
  int mLapSec;

  always @(posedge clk) begin
    bit ps, pl, clrNext;
    if (reset) begin
      modelValid = 1;
      mCounting = 0; mStopped = 0; mFrozen = 0; mClr = 0;
      mPrevSs = 1; mPrevLap = 1; mLapSec = 0;
    end else if (modelValid) begin
      ps = btn_ss && !mPrevSs;
      pl = btn_lap && !mPrevLap;
      clrNext = 0;
      if (ps) begin
        if (mCounting) begin
          mCounting = 0; mStopped = 1; mFrozen = 0;
        end else begin
          mCounting = 1; mStopped = 0; mFrozen = 0;
        end
      end else if (pl) begin
        if (mCounting && !mFrozen) begin
          mFrozen = 1; mLapSec = int'(ts) * 10 + int'(ss);
        end else if (mFrozen) begin
          mFrozen = 0;
        end else if (mStopped) begin
          mStopped = 0; mLapSec = 0; clrNext = 1;
        end
      end
      mClr = clrNext;
      mPrevSs = btn_ss;
      mPrevLap = btn_lap;
    end
  end

  always @(negedge clk) begin
    int expEn, expMin, expTs, expSs;
    if (modelValid) begin
      expEn  = (tick && mCounting) ? 1 : 0;
      expMin = (expEn == 1 && ts == 3'd5 && ss == 4'd9) ? 1 : 0;
      expTs  = mFrozen ? mLapSec / 10 : int'(ts);
      expSs  = mFrozen ? mLapSec % 10 : int'(ss);
      checkOutput("model cnt_en", int'(cnt_en), expEn);
      checkOutput("model min_tick", int'(min_tick), expMin);
      checkOutput("model ts_out", int'(ts_out), expTs);
      checkOutput("model ss_out", int'(ss_out), expSs);
      checkOutput("model running", int'(running), int'(mCounting));
      checkOutput("model cnt_clr", int'(cnt_clr), int'(mClr));
    end
  end

  // Drives one cycle of inputs; on return the caller observes that cycle's outputs.
  task automatic applyStimulus(input logic t, input logic s, input logic l);
    @(posedge clk);
    #2;
    tick = t; btn_ss = s; btn_lap = l;
    #1;
  endtask

  task automatic pulseTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pressSs();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressLap();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset running", int'(running), 0);
    checkOutput("reset cnt_en", int'(cnt_en), 0);
    checkOutput("reset cnt_clr", int'(cnt_clr), 0);
    checkOutput("reset ts_out", int'(ts_out), 0);
    checkOutput("reset ss_out", int'(ss_out), 0);

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("press latency running", int'(running), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("start running", int'(running), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("run tick cnt_en", int'(cnt_en), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("three ticks secs", secs, 3);
    checkOutput("three ticks enCount", enCount, 3);
    checkOutput("three ticks ts_out", int'(ts_out), 0);
    checkOutput("three ticks ss_out", int'(ss_out), 3);

    pulseTicks(9);
    pressLap();
    checkOutput("lap hold ts_out", int'(ts_out), 1);
    checkOutput("lap hold ss_out", int'(ss_out), 2);
    pulseTicks(4);
    checkOutput("lap live secs", secs, 16);
    checkOutput("lap frozen ts_out", int'(ts_out), 1);
    checkOutput("lap frozen ss_out", int'(ss_out), 2);
    checkOutput("lap running", int'(running), 1);
    pressLap();
    checkOutput("lap release ts_out", int'(ts_out), 1);
    checkOutput("lap release ss_out", int'(ss_out), 6);

    pulseTicks(43);
    checkOutput("pre-wrap secs", secs, 59);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrap min_tick", int'(min_tick), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("wrap min_tick low", int'(min_tick), 0);
    checkOutput("wrap ts_out", int'(ts_out), 0);
    checkOutput("wrap ss_out", int'(ss_out), 0);

    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("simultaneous stops", int'(running), 0);
    pressSs();
    checkOutput("restart running", int'(running), 1);
    checkOutput("restart not frozen ss_out", int'(ss_out), 0);

    pulseTicks(7);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stop with tick cnt_en", int'(cnt_en), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stopped running", int'(running), 0);
    checkOutput("stopped secs", secs, 8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stopped tick cnt_en", int'(cnt_en), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stopped secs hold", secs, 8);

    pressSs();
    pulseTicks(16);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lap with tick secs", secs, 25);
    checkOutput("lap with tick ts_out", int'(ts_out), 2);
    checkOutput("lap with tick ss_out", int'(ss_out), 4);
    pressSs();
    checkOutput("lap to stop running", int'(running), 0);
    checkOutput("lap to stop ss_out live", int'(ss_out), 5);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear not yet", int'(cnt_clr), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clear pulse", int'(cnt_clr), 1);
    checkOutput("clear cycle cnt_en", int'(cnt_en), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clear one cycle", int'(cnt_clr), 0);
    checkOutput("clear secs", secs, 0);
    checkOutput("clear running", int'(running), 0);

    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("held through reset", int'(running), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pressSs();
    checkOutput("re-press running", int'(running), 1);

    pulseTicks(3);
    pressLap();
    pulseTicks(2);
    checkOutput("lap before reset ss_out", int'(ss_out), 3);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset in lap cnt_en", int'(cnt_en), 0);
    checkOutput("reset in lap running", int'(running), 0);
    checkOutput("reset in lap ss_out", int'(ss_out), 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
